// File: rtl/matrix_mac_mul.sv
// matrix_mac_mul: single-MAC time-multiplexed P = A*B (+C) engine with start/busy/done handshake.
// Define MATRIX_MAC_SAT_EN to saturate P elements and report overflow; otherwise P wraps.
module matrix_mac_mul #(
  parameter int ROWS_A = 2,
  parameter int COLS_A = 3,
  parameter int COLS_B = 2,
  parameter int WIDTH = 16,
  parameter int ACC_WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic accumulate,
  input  logic [ROWS_A*COLS_A*WIDTH-1:0] op_a,
  input  logic [COLS_A*COLS_B*WIDTH-1:0] op_b,
  input  logic [ROWS_A*COLS_B*ACC_WIDTH-1:0] op_c,
  output logic [ROWS_A*COLS_B*ACC_WIDTH-1:0] prod,
  output logic busy,
  output logic done,
  output logic overflow
);
  localparam int PW = 2*WIDTH + $clog2(COLS_A+1);
  localparam int AW = (PW > ACC_WIDTH ? PW : ACC_WIDTH) + 1;
  localparam int IW = $clog2(ROWS_A+1);
  localparam int JW = $clog2(COLS_B+1);
  localparam int KW = $clog2(COLS_A+1);
  localparam logic [IW-1:0] I_LAST = IW'(ROWS_A-1);
  localparam logic [JW-1:0] J_LAST = JW'(COLS_B-1);
  localparam logic [KW-1:0] K_LAST = KW'(COLS_A-1);
  typedef enum logic [1:0] {IDLE, MAC, WRITE} state_t;
  state_t state, state_nxt;
  logic [ROWS_A*COLS_A*WIDTH-1:0] a_r;
  logic [COLS_A*COLS_B*WIDTH-1:0] b_r;
  logic [ROWS_A*COLS_B*ACC_WIDTH-1:0] c_r;
  logic acc_mode;
  logic [IW-1:0] i;
  logic [JW-1:0] j;
  logic [KW-1:0] k;
  logic signed [AW-1:0] acc, acc_init, sum;
  logic signed [WIDTH-1:0] a_el, b_el;
  logic signed [2*WIDTH-1:0] mul;
  logic signed [ACC_WIDTH-1:0] c_el, out_el;
  logic accept, mac_en, wr_en, k_last, j_last, last_el;
  int a_idx, b_idx, p_idx, c_idx;
  always_ff @(posedge clk) state <= rst ? IDLE : state_nxt;
  always_comb
    state_nxt = state == IDLE ? (start ? MAC : IDLE) :
                state == MAC  ? (k_last ? WRITE : MAC) :
                                (last_el ? IDLE : MAC);
  always_comb begin
    accept = state == IDLE && start;
    mac_en = state == MAC;
    wr_en = state == WRITE;
  end
  always_comb begin
    k_last = k == K_LAST;
    j_last = j == J_LAST;
    last_el = i == I_LAST && j_last;
    a_idx = (int'(i)*COLS_A + int'(k))*WIDTH;
    b_idx = (int'(k)*COLS_B + int'(j))*WIDTH;
    p_idx = int'(i)*COLS_B + int'(j);
    c_idx = last_el ? 0 : p_idx + 1;
    a_el = a_r[a_idx +: WIDTH];
    b_el = b_r[b_idx +: WIDTH];
    mul = (2*WIDTH)'(a_el) * (2*WIDTH)'(b_el);
    sum = acc + AW'(mul);
    // at accept the first element's C comes straight from the port
    c_el = accept ? op_c[ACC_WIDTH-1:0] : c_r[c_idx*ACC_WIDTH +: ACC_WIDTH];
    acc_init = (accept ? accumulate : acc_mode) ? AW'(c_el) : '0;
  end
`ifdef MATRIX_MAC_SAT_EN
  localparam logic signed [AW-1:0] PMAX = {{(AW-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] NMIN = {{(AW-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}};
  logic clip;
  always_comb begin
    clip = acc > PMAX || acc < NMIN;
    out_el = acc > PMAX ? PMAX[ACC_WIDTH-1:0] : acc < NMIN ? NMIN[ACC_WIDTH-1:0] : acc[ACC_WIDTH-1:0];
  end
  always_ff @(posedge clk) overflow <= rst || accept ? 1'b0 : overflow | (wr_en & clip);
`else
  assign out_el = acc[ACC_WIDTH-1:0];
  assign overflow = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      i <= '0;
      j <= '0;
      k <= '0;
      acc <= '0;
      prod <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= wr_en && last_el;
      if (accept) begin
        a_r <= op_a;
        b_r <= op_b;
        c_r <= op_c;
        acc_mode <= accumulate;
        i <= '0;
        j <= '0;
        k <= '0;
        acc <= acc_init;
        busy <= 1'b1;
      end
      if (mac_en) begin
        acc <= sum;
        k <= k + KW'(1);
      end
      if (wr_en) begin
        prod[p_idx*ACC_WIDTH +: ACC_WIDTH] <= out_el;
        k <= '0;
        acc <= acc_init;
        j <= j_last ? '0 : j + JW'(1);
        i <= last_el ? '0 : j_last ? i + IW'(1) : i;
        if (last_el) busy <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_matrix_mac_mul.sv
// tb_matrix_mac_mul: table vectors, randomized runs against an arithmetic model, and handshake corner cases.
module tb_matrix_mac_mul;
  localparam int M = 2, K = 3, N = 2, W = 16;
`ifdef MATRIX_MAC_SAT_EN
  localparam longint P16 = 32767;
  localparam bit OVF16 = 1'b1;
`else
  localparam longint P16 = 3;
  localparam bit OVF16 = 1'b0;
`endif
  typedef struct packed {
    logic [M*K-1:0][W-1:0] a;
    logic [K*N-1:0][W-1:0] b;
    logic [M*N-1:0][31:0] c;
    logic accm;
    logic [M*N-1:0][31:0] exp;
  } vec_t;
  logic clk = 0, rst = 1, start = 0, start16 = 0, accumulate = 0;
  logic [M*K*W-1:0] op_a = '0;
  logic [K*N*W-1:0] op_b = '0;
  logic [M*N*32-1:0] op_c = '0;
  logic [M*N*16-1:0] op_c16 = '0;
  logic [M*N*32-1:0] prod;
  logic [M*N*16-1:0] prod16;
  logic busy, done, overflow, busy16, done16, overflow16;
  int checks = 0, errors = 0;
  vec_t tbl[4];
  vec_t v;
  bit clip, any;
  int pulses;
  matrix_mac_mul u_dut (
    .clk(clk), .rst(rst), .start(start), .accumulate(accumulate),
    .op_a(op_a), .op_b(op_b), .op_c(op_c),
    .prod(prod), .busy(busy), .done(done), .overflow(overflow)
  );
  matrix_mac_mul #(.ACC_WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .accumulate(accumulate),
    .op_a(op_a), .op_b(op_b), .op_c(op_c16),
    .prod(prod16), .busy(busy16), .done(done16), .overflow(overflow16)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  function automatic longint pel(input int e);
    return longint'($signed(prod[e*32 +: 32]));
  endfunction
  function automatic longint pel16(input int e);
    return longint'($signed(prod16[e*16 +: 16]));
  endfunction
  // Element e of A*B (+C) in plain integer arithmetic, then fitted to aw bits.
  function automatic longint ref_el(input logic [M*K-1:0][W-1:0] a, input logic [K*N-1:0][W-1:0] b,
                                    input logic [M*N-1:0][31:0] c, input logic accm, input int e,
                                    input int aw, output bit clipped);
    longint s, lim;
    int r, col;
    r = e / N;
    col = e % N;
    s = accm ? longint'($signed(c[e])) : 0;
    for (int kk = 0; kk < K; kk++)
      s += longint'($signed(a[r*K+kk])) * longint'($signed(b[kk*N+col]));
    lim = longint'(1) <<< (aw-1);
    clipped = 0;
`ifdef MATRIX_MAC_SAT_EN
    if (s > lim-1) begin s = lim-1; clipped = 1; end
    else if (s < -lim) begin s = -lim; clipped = 1; end
`else
    s = s % (2*lim);
    if (s >= lim) s -= 2*lim;
    else if (s < -lim) s += 2*lim;
`endif
    return s;
  endfunction
  task automatic apply(input vec_t x);
    op_a = x.a;
    op_b = x.b;
    op_c = x.c;
    accumulate = x.accm;
    for (int e = 0; e < M*N; e++) op_c16[e*16 +: 16] = x.c[e][15:0];
  endtask
  // Called at the negedge right after the accept edge; returns at the negedge after done.
  task automatic wait_done(input bit s16, input string tag);
    int cnt;
    bit busy_ok;
    cnt = 0;
    busy_ok = 1;
    while (!(s16 ? done16 : done) && cnt < 100) begin
      busy_ok = busy_ok & (s16 ? busy16 : busy);
      @(negedge clk);
      cnt++;
    end
    check($sformatf("%s latency", tag), cnt, 16);
    check($sformatf("%s busy during run", tag), busy_ok, 1);
    check($sformatf("%s busy at done", tag), s16 ? busy16 : busy, 0);
    @(negedge clk);
    check($sformatf("%s done single cycle", tag), s16 ? done16 : done, 0);
  endtask
  task automatic run_op(input bit s16, input string tag);
    @(negedge clk);
    if (s16) start16 = 1; else start = 1;
    @(negedge clk);
    start = 0;
    start16 = 0;
    wait_done(s16, tag);
  endtask
  initial begin
    for (int i = 0; i < M*K; i++) begin
      tbl[0].a[i] = 16'(i+1);
      tbl[0].b[i] = 16'(i+7);
    end
    tbl[0].c = '0;
    tbl[0].accm = 0;
    tbl[0].exp = {32'd154, 32'd139, 32'd64, 32'd58};
    tbl[1] = tbl[0];
    tbl[1].c = {4{32'd100}};
    tbl[1].accm = 1;
    tbl[1].exp = {32'd254, 32'd239, 32'd164, 32'd158};
    tbl[2] = tbl[1];
    tbl[2].accm = 0;
    tbl[2].exp = tbl[0].exp;
    tbl[3].a = {6{16'hFFFF}};
    tbl[3].b = {6{16'd32767}};
    tbl[3].c = {4{32'hFFFF_FFFB}};
    tbl[3].accm = 1;
    tbl[3].exp = {4{32'hFFFE_7FFE}};
    repeat (3) @(negedge clk);
    rst = 0;
    check("reset prod bits", $countones(prod), 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset overflow", overflow, 0);
    for (int t = 0; t < 4; t++) begin
      apply(tbl[t]);
      run_op(0, $sformatf("vec%0d", t));
      for (int e = 0; e < M*N; e++)
        check($sformatf("vec%0d P%0d", t, e), pel(e), longint'($signed(tbl[t].exp[e])));
      check($sformatf("vec%0d overflow", t), overflow, 0);
    end
    v = '0;
    v.a = {6{16'd32767}};
    v.b = {6{16'd32767}};
    apply(v);
    run_op(1, "acc16");
    for (int e = 0; e < M*N; e++) check($sformatf("acc16 P%0d", e), pel16(e), P16);
    check("acc16 overflow", overflow16, OVF16);
    apply(tbl[0]);
    run_op(1, "acc16 rerun");
    for (int e = 0; e < M*N; e++)
      check($sformatf("acc16 rerun P%0d", e), pel16(e), longint'($signed(tbl[0].exp[e])));
    check("acc16 rerun overflow cleared", overflow16, 0);
    for (int it = 0; it < 20; it++) begin
      for (int i = 0; i < M*K; i++) begin
        v.a[i] = (it % 4 == 0) ? 16'h8000 : 16'($urandom);
        v.b[i] = (it % 4 == 0) ? ($urandom_range(1) ? 16'h8000 : 16'h7FFF) : 16'($urandom);
      end
      for (int e = 0; e < M*N; e++) v.c[e] = $urandom;
      v.accm = 1'($urandom);
      apply(v);
      run_op(0, $sformatf("rand%0d", it));
      any = 0;
      for (int e = 0; e < M*N; e++) begin
        check($sformatf("rand%0d P%0d", it, e), pel(e), ref_el(v.a, v.b, v.c, v.accm, e, 32, clip));
        any |= clip;
      end
      check($sformatf("rand%0d overflow", it), overflow, any);
    end
    apply(tbl[0]);
    v = tbl[0];
    for (int i = 0; i < M*K; i++) v.a[i] = 16'($urandom);
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    pulses = 0;
    for (int n = 0; n <= 16; n++) begin
      if (n > 0) @(negedge clk);
      if (done) pulses++;
      if (n == 3) op_a = v.a;
      start = (n == 5 || n == 10 || n == 16);
    end
    check("ignored start done pulses", pulses, 1);
    check("ignored start done at 16", done, 1);
    for (int e = 0; e < M*N; e++)
      check($sformatf("latched operands P%0d", e), pel(e), longint'($signed(tbl[0].exp[e])));
    @(negedge clk);
    start = 0;
    check("back-to-back accepted", busy, 1);
    check("back-to-back done low", done, 0);
    wait_done(0, "b2b");
    for (int e = 0; e < M*N; e++)
      check($sformatf("b2b P%0d", e), pel(e), ref_el(v.a, v.b, v.c, v.accm, e, 32, clip));
    apply(tbl[1]);
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (7) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    check("midrun reset prod bits", $countones(prod), 0);
    check("midrun reset busy", busy, 0);
    check("midrun reset done", done, 0);
    check("midrun reset overflow", overflow, 0);
    apply(tbl[0]);
    run_op(0, "after reset");
    for (int e = 0; e < M*N; e++)
      check($sformatf("after reset P%0d", e), pel(e), longint'($signed(tbl[0].exp[e])));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
